// File: rtl/pd_feedback_controller.sv
// pd_feedback_controller: periodic PD controller (clock, resetN, enable, position -> feedback, sampleValid, busy, saturated)
module pd_feedback_controller #(
  parameter int PERIOD = 16,
  parameter logic signed [7:0] SETPOINT = 8'sd0,
  parameter logic signed [7:0] KP = 8'sd3,
  parameter logic signed [7:0] KD = 8'sd5,
  parameter int SHIFT = 4
) (
  input  logic clock,
  input  logic resetN,
  input  logic enable,
  input  logic signed [7:0] position,
  output logic signed [7:0] feedback,
  output logic sampleValid,
  output logic busy,
  output logic saturated
);
  localparam int CW = $clog2(PERIOD);
  typedef enum logic [2:0] {IDLE, ERR, MUL, SUM, OUT} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] count;
  logic tick, primed, hi, lo;
  logic signed [7:0] pos_reg;
  logic signed [8:0] err, err_c, prev_err;
  logic signed [9:0] deriv, deriv_c;
  logic signed [16:0] p_term;
  logic signed [17:0] d_term;
  logic signed [18:0] sum;
  assign tick = enable && count == CW'(PERIOD - 1);
  assign busy = state != IDLE;
  assign err_c = 9'(SETPOINT) - 9'(pos_reg);
  assign deriv_c = primed ? 10'(err_c) - 10'(prev_err) : '0;
  assign hi = sum > 19'sd127;
  assign lo = sum < -19'sd127;
  always_ff @(posedge clock)
    if (!resetN) count <= '0;
    else if (enable) count <= tick ? '0 : count + 1'b1;
  always_ff @(posedge clock)
    if (!resetN) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (tick ? ERR : IDLE) :
                state == ERR  ? MUL :
                state == MUL  ? SUM :
                state == SUM  ? OUT : IDLE;
  end
  always_ff @(posedge clock)
    if (!resetN) begin
      pos_reg <= '0;
      err <= '0;
      deriv <= '0;
      prev_err <= '0;
      primed <= 1'b0;
      p_term <= '0;
      d_term <= '0;
      sum <= '0;
      feedback <= '0;
      saturated <= 1'b0;
      sampleValid <= 1'b0;
    end else begin
      sampleValid <= 1'b0;
      if (state == IDLE && tick) pos_reg <= position;
      if (state == ERR) begin
        err <= err_c;
        deriv <= deriv_c;
        prev_err <= err_c;
        primed <= 1'b1;
      end
      if (state == MUL) begin
        p_term <= 17'(KP) * 17'(err);
        d_term <= 18'(KD) * 18'(deriv);
      end
      if (state == SUM) sum <= (19'(p_term) + 19'(d_term)) >>> SHIFT;
      if (state == OUT) begin
        feedback <= hi ? 8'sd127 : lo ? -8'sd127 : sum[7:0];
        saturated <= hi | lo;
        sampleValid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pd_feedback_controller.sv
// tb_pd_feedback_controller: scoreboard bench for default-gain and high-gain controllers
module tb_pd_feedback_controller;
  typedef struct {int due; int fb; int sat;} ent_t;
  logic clock = 1'b0;
  logic resetN, enable;
  logic signed [7:0] position;
  logic signed [7:0] fb_d, fb_s;
  logic sv_d, sv_s, busy_d, busy_s, sat_d, sat_s;
  int vectors = 0, errors = 0, cyc = 0, mcnt = 0, prev = 0, err, deriv, rel, last;
  int mfb_d = 0, msat_d = 0, mfb_s = 0, msat_s = 0;
  bit primed = 1'b0, ev;
  ent_t qd[$], qs[$], e;
  pd_feedback_controller u_dut (
    .clock(clock), .resetN(resetN), .enable(enable), .position(position),
    .feedback(fb_d), .sampleValid(sv_d), .busy(busy_d), .saturated(sat_d)
  );
  pd_feedback_controller #(.KP(8'sd100), .KD(8'sd0)) u_sat (
    .clock(clock), .resetN(resetN), .enable(enable), .position(position),
    .feedback(fb_s), .sampleValid(sv_s), .busy(busy_s), .saturated(sat_s)
  );
  always #5 clock = ~clock;
  task automatic chk(string tag, int got, int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic ent_t calc(int kp, int kd, int er, int dv, int due);
    int s;
    s = (kp * er + kd * dv) >>> 4;
    calc.due = due;
    calc.sat = (s > 127 || s < -127) ? 1 : 0;
    calc.fb = s > 127 ? 127 : s < -127 ? -127 : s;
  endfunction
  always @(posedge clock) begin
    cyc++;
    if (!resetN) begin
      mcnt = 0;
      prev = 0;
      primed = 1'b0;
      qd.delete();
      qs.delete();
      mfb_d = 0; msat_d = 0; mfb_s = 0; msat_s = 0;
    end else if (enable) begin
      if (mcnt == 15) begin
        err = -int'(position);
        deriv = primed ? err - prev : 0;
        prev = err;
        primed = 1'b1;
        qd.push_back(calc(3, 5, err, deriv, cyc + 4));
        qs.push_back(calc(100, 0, err, deriv, cyc + 4));
        mcnt = 0;
      end else mcnt++;
    end
    #1;
    ev = qd.size() != 0 && qd[0].due == cyc;
    chk("d_valid", int'(sv_d), int'(ev));
    if (ev) begin
      e = qd.pop_front();
      mfb_d = e.fb;
      msat_d = e.sat;
    end
    chk("d_feedback", int'(fb_d), mfb_d);
    chk("d_saturated", int'(sat_d), msat_d);
    chk("d_busy", int'(busy_d), int'(qd.size() != 0));
    ev = qs.size() != 0 && qs[0].due == cyc;
    chk("s_valid", int'(sv_s), int'(ev));
    if (ev) begin
      e = qs.pop_front();
      mfb_s = e.fb;
      msat_s = e.sat;
    end
    chk("s_feedback", int'(fb_s), mfb_s);
    chk("s_saturated", int'(sat_s), msat_s);
    chk("s_busy", int'(busy_s), int'(qs.size() != 0));
  end
  task automatic wait_valid(int bound);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!sv_d && n < bound);
    chk("wait_valid", int'(sv_d), 1);
  endtask
  task automatic wait_busy(int bound);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!busy_d && n < bound);
    chk("wait_busy", int'(busy_d), 1);
  endtask
  initial begin
    resetN = 1'b0;
    enable = 1'b1;
    position = 8'sd40;
    repeat (2) @(negedge clock);
    chk("reset_fb", int'(fb_d), 0);
    chk("reset_busy", int'(busy_d), 0);
    resetN = 1'b1;
    rel = cyc;
    wait_valid(40);
    chk("first_latency", cyc - rel, 20);
    chk("first_fb", int'(fb_d), -8);
    chk("first_sat", int'(sat_d), 0);
    chk("first_fb_hi_gain", int'(fb_s), -127);
    last = cyc;
    position = 8'sd20;
    wait_valid(40);
    chk("deriv_gap", cyc - last, 16);
    chk("deriv_fb", int'(fb_d), 2);
    resetN = 1'b0;
    position = -8'sd100;
    @(negedge clock);
    resetN = 1'b1;
    wait_valid(40);
    chk("sat_hi_fb", int'(fb_s), 127);
    chk("sat_hi_flag", int'(sat_s), 1);
    position = 8'sd0;
    wait_valid(40);
    chk("sat_clear_fb", int'(fb_s), 0);
    chk("sat_clear_flag", int'(sat_s), 0);
    position = 8'sd100;
    wait_valid(40);
    chk("sat_lo_fb", int'(fb_s), -127);
    chk("sat_lo_flag", int'(sat_s), 1);
    position = 8'sd40;
    for (int i = 0; i < 40 && mcnt != 10; i++) @(negedge clock);
    enable = 1'b0;
    repeat (7) @(negedge clock);
    enable = 1'b1;
    last = cyc;
    wait_valid(40);
    chk("gate_gap", cyc - last, 10);
    wait_busy(40);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    enable = 1'b1;
    wait_valid(10);
    wait_busy(40);
    @(negedge clock);
    resetN = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    position = 8'sd60;
    chk("rst_fb", int'(fb_d), 0);
    chk("rst_busy", int'(busy_d), 0);
    chk("rst_valid", int'(sv_d), 0);
    rel = cyc;
    wait_valid(40);
    chk("rst_latency", cyc - rel, 20);
    chk("rst_first_fb", int'(fb_d), -12);
    repeat (1500) begin
      @(negedge clock);
      position = 8'($urandom_range(0, 255));
      enable = $urandom_range(0, 7) != 0;
      resetN = $urandom_range(0, 399) != 0;
    end
    resetN = 1'b1;
    enable = 1'b0;
    repeat (8) @(negedge clock);
    chk("drain", qd.size() + qs.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
